// File: rtl/dual_port_fifo_ctrl.sv
// dual_port_fifo_ctrl: FIFO controller owning both ports of an external
// dual-port RAM, with a 2-entry output buffer hiding the read latency.
module dual_port_fifo_ctrl #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic [ADDR_W+1:0] count,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic [DATA_W-1:0] ram_data_a,
    output logic              ram_we_a,
    output logic [ADDR_W-1:0] ram_addr_b,
    output logic [DATA_W-1:0] ram_data_b,
    output logic              ram_we_b,
    input  logic [DATA_W-1:0] ram_q_b
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   mem_cnt;
    logic              inflight;
    logic [DATA_W-1:0] obuf [2];
    logic [1:0]        out_cnt;
    logic              hd;
    logic              tl;
    logic              push;
    logic              pop;
    logic              issue;
    logic [2:0]        occ;

    // Handshake and read-issue decisions from registered state
    always_comb begin
        wr_ready = (mem_cnt < DEPTH_C);
        rd_valid = (out_cnt != 2'd0);
        rd_data  = obuf[hd];
        push     = wr_valid & wr_ready;
        pop      = rd_valid & rd_ready;
        // Buffer slots that stay claimed after this cycle's pop
        occ      = {1'b0, out_cnt} + {2'b0, inflight} - {2'b0, pop};
        issue    = (mem_cnt != '0) & (occ < 3'd2) & ~clr;
        // A loading word lands behind the current head entry
        tl       = hd ^ out_cnt[0];
    end

    // RAM port drive; port B only ever reads
    always_comb begin
        ram_addr_a = wr_ptr;
        ram_data_a = wr_data;
        ram_we_a   = push & ~clr & rst_n;
        ram_addr_b = rd_ptr;
        ram_data_b = '0;
        ram_we_b   = 1'b0;
    end

    // Occupancy seen by the datapath: RAM words, in-flight read, buffer
    always_comb begin
        count = (ADDR_W+2)'(mem_cnt)
              + (ADDR_W+2)'(inflight)
              + (ADDR_W+2)'(out_cnt);
    end

    // RAM-side pointers and stored-word count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
        end else if (clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
        end else begin
            wr_ptr  <= wr_ptr + ADDR_W'(push);
            rd_ptr  <= rd_ptr + ADDR_W'(issue);
            mem_cnt <= mem_cnt + (ADDR_W+1)'(push) - (ADDR_W+1)'(issue);
        end
    end

    // One-cycle read tracking; a flush drops the pending word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
        end else if (clr) begin
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
        end
    end

    // Output buffer storage, loaded from RAM read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obuf[0] <= '0;
            obuf[1] <= '0;
        end else if (clr) begin
            obuf[0] <= '0;
            obuf[1] <= '0;
        end else if (inflight) begin
            obuf[tl] <= ram_q_b;
        end
    end

    // Output buffer occupancy and head index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cnt <= '0;
            hd      <= 1'b0;
        end else if (clr) begin
            out_cnt <= '0;
            hd      <= 1'b0;
        end else begin
            out_cnt <= out_cnt + {1'b0, inflight} - {1'b0, pop};
            hd      <= hd ^ pop;
        end
    end

endmodule

// File: tb/tb_dual_port_fifo_ctrl.sv
// tb_dual_port_fifo_ctrl: bench for dual_port_fifo_ctrl with a RAM model
// and a queue-based reference of the FIFO contents.
module tb_dual_port_fifo_ctrl;

    localparam int DW = 4;
    localparam int AW = 3;
    localparam int DP = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_ready = 1'b0;
    logic          wr_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [AW+1:0] count;
    logic [AW-1:0] ram_addr_a;
    logic [DW-1:0] ram_data_a;
    logic          ram_we_a;
    logic [AW-1:0] ram_addr_b;
    logic [DW-1:0] ram_data_b;
    logic          ram_we_b;
    logic [DW-1:0] ram_q_b = '0;
    logic [DW-1:0] ram [DP];

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] oq[$];
    logic          fv = 1'b0;
    logic [DW-1:0] fw = '0;

    logic          s_rv;
    logic [DW-1:0] s_rd;
    int            s_cnt;
    logic          s_wr;

    typedef struct {
        logic          c;
        logic          wv;
        logic [DW-1:0] wd;
        logic          rr;
        logic          erv;
        logic [DW-1:0] erd;
        int            ecnt;
        logic          ewr;
        logic          chkd;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    dual_port_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .count(count),
        .ram_addr_a(ram_addr_a), .ram_data_a(ram_data_a), .ram_we_a(ram_we_a),
        .ram_addr_b(ram_addr_b), .ram_data_b(ram_data_b), .ram_we_b(ram_we_b),
        .ram_q_b(ram_q_b)
    );

    // Synchronous dual-port RAM with registered port-B read
    always @(posedge clk) begin
        if (ram_we_a) ram[ram_addr_a] <= ram_data_a;
        ram_q_b <= ram[ram_addr_b];
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic c, input logic wv,
                        input logic [DW-1:0] wd, input logic rr);
        logic pu;
        logic po;
        logic is;
        clr = c;
        wr_valid = wv;
        wr_data = wd;
        rd_ready = rr;
        @(negedge clk);
        s_rv = rd_valid;
        s_rd = rd_data;
        s_cnt = int'(count);
        s_wr = wr_ready;
        chk("m_wr_ready", int'(wr_ready), int'(mq.size() < DP));
        chk("m_rd_valid", int'(rd_valid), int'(oq.size() != 0));
        chk("m_count", int'(count), mq.size() + oq.size() + int'(fv));
        if (oq.size() != 0) chk("m_rd_data", int'(rd_data), int'(oq[0]));
        pu = wv && (mq.size() < DP);
        po = rr && (oq.size() != 0);
        chk("m_we_a", int'(ram_we_a), int'(pu && !c));
        chk("m_port_b", int'({ram_we_b, ram_data_b}), 0);
        if (c) begin
            mq.delete();
            oq.delete();
            fv = 1'b0;
        end else begin
            is = (mq.size() != 0) && ((oq.size() + int'(fv) - int'(po)) < 2);
            if (po) void'(oq.pop_front());
            if (fv) oq.push_back(fw);
            fv = is;
            if (is) fw = mq.pop_front();
            if (pu) mq.push_back(wd);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic mid_reset();
        @(negedge clk);
        clr = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_count", int'(count), 0);
        chk("arst_rd_valid", int'(rd_valid), 0);
        chk("arst_wr_ready", int'(wr_ready), 1);
        mq.delete();
        oq.delete();
        fv = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        int first;
        int last;
        int maxc;
        logic [DW-1:0] exp_q[$];

        // Reset with a push request held
        rst_n = 1'b0;
        wr_valid = 1'b1;
        wr_data = 4'h3;
        repeat (2) @(negedge clk);
        chk("rst_we_a", int'(ram_we_a), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_wr_ready", int'(wr_ready), 1);
        chk("rst_rd_data", int'(rd_data), 0);
        wr_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single word latency, then flush with a read in flight
        tbl.push_back('{1'b0, 1'b1, 4'hA, 1'b0, 1'b0, 4'h0, 0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'hA, 1, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 4'h0, 0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'h2, 1'b0, 1'b0, 4'h0, 1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 4'h0, 2, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 4'h7, 1'b1, 1'b1, 4'h1, 3, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 4'h5, 1'b0, 1'b0, 4'h0, 0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h5, 1, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 0, 1'b1, 1'b0});
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].c, tbl[i].wv, tbl[i].wd, tbl[i].rr);
            chk($sformatf("tbl%0d_rd_valid", i), int'(s_rv), int'(tbl[i].erv));
            chk($sformatf("tbl%0d_count", i), s_cnt, tbl[i].ecnt);
            chk($sformatf("tbl%0d_wr_ready", i), int'(s_wr), int'(tbl[i].ewr));
            if (tbl[i].chkd)
                chk($sformatf("tbl%0d_rd_data", i), int'(s_rd), int'(tbl[i].erd));
        end

        // Streaming: one push and one pop per cycle
        got = 0;
        first = -1;
        last = -1;
        maxc = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            step(1'b0, cyc < 20, DW'(cyc), 1'b1);
            if (s_cnt > maxc) maxc = s_cnt;
            if (s_rv) begin
                if (first < 0) first = cyc;
                last = cyc;
                chk("stream_data", int'(s_rd), got % 16);
                got++;
            end
        end
        chk("stream_words", got, 20);
        chk("stream_first", first, 3);
        chk("stream_last", last, 22);
        chk("stream_max_count", int'(maxc <= 3), 1);

        // Fill to capacity, refused pushes, then drain in order
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, DW'(i), 1'b0);
        step(1'b0, 1'b1, 4'hF, 1'b0);
        chk("fill_wr_ready", int'(s_wr), 0);
        chk("fill_count", s_cnt, 10);
        step(1'b0, 1'b1, 4'hC, 1'b1);
        chk("full_pop_wr_ready", int'(s_wr), 0);
        chk("full_pop_count", s_cnt, 10);
        chk("full_pop_data", int'(s_rd), 0);
        step(1'b0, 1'b1, 4'hC, 1'b0);
        chk("after_issue_wr_ready", int'(s_wr), 1);
        chk("after_issue_count", s_cnt, 9);
        for (int i = 1; i < 10; i++) exp_q.push_back(DW'(i));
        exp_q.push_back(4'hC);
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 10; cyc++) begin
            step(1'b0, 1'b0, 4'h0, 1'b1);
            if (s_rv) begin
                chk("drain_data", int'(s_rd), int'(exp_q[got]));
                got++;
            end
        end
        chk("drain_words", got, 10);
        step(1'b0, 1'b0, 4'h0, 1'b0);
        chk("drain_empty_count", s_cnt, 0);

        // Randomised traffic against the queue model
        for (int n = 0; n < 600; n++) begin
            if (n == 300) mid_reset();
            step($urandom_range(0, 39) == 0,
                 $urandom_range(0, 3) != 0,
                 DW'($urandom),
                 $urandom_range(0, 2) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
